zdraw_scheduler: RTL and testbench



---
 rtl/zdraw_scheduler.sv | 264 ++++++++++++++++++++++++++
 tb/tb_zdraw_scheduler.sv | 487 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zdraw_scheduler.sv
// zdraw_scheduler: sequences the LCD power-on draw and the periodic refresh
// frame, issuing commands to the draw core over an enable/done handshake.
// Ports: clk, rst_n (async active-low), en, iPause, per-channel pulse
//   counters and update strobes, status operands (accumulated, gain,
//   interval, max/min); draw-core handshake oDraw_En/oDraw_Cmd/oDraw_Data1/2
//   and iDraw_Done; status oFrame_Done, oTimeout, oTimeout_Cnt, oBusy.
// Option: define ZDRAW_SKIP_UNCHANGED_EN to skip cmds 8/9/10 whose operands
//   match the values last issued (always issued on the first frame after INIT).
module zdraw_scheduler #(
    parameter int          NUM_CH      = 2,
    parameter int          DATA_W      = 32,
    parameter int          TIMEOUT_CYC = 1048576,
    parameter logic [15:0] BG_COLOR    = 16'h0000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     iPause,
    input  logic [NUM_CH-1:0]        iData_Update,
    input  logic [NUM_CH*DATA_W-1:0] iPulse_Counter,
    input  logic [DATA_W-1:0]        iPulseCounter_Accumulated,
    input  logic [7:0]               iPulseCounter_Gain_Divider,
    input  logic [7:0]               iTime_Interval_Selection,
    input  logic [15:0]              iMaxPulseCounter,
    input  logic [15:0]              iMinPulseCounter,
    output logic                     oDraw_En,
    output logic [3:0]               oDraw_Cmd,
    output logic [31:0]              oDraw_Data1,
    output logic [31:0]              oDraw_Data2,
    input  logic                     iDraw_Done,
    output logic                     oFrame_Done,
    output logic                     oTimeout,
    output logic [7:0]               oTimeout_Cnt,
    output logic                     oBusy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLR   = 3'd1;
    localparam logic [2:0] S_IMG   = 3'd2;
    localparam logic [2:0] S_LBL   = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_FRAME = 3'd5;

    localparam int LAST = NUM_CH + 5;
    localparam int WD_W = $clog2(TIMEOUT_CYC);
    // Expiry is taken on the edge where the counter would reach TIMEOUT_CYC-1
    localparam logic [WD_W-1:0] WD_LIM = WD_W'(TIMEOUT_CYC - 2);

    logic [2:0]        state_q, state_d;
    logic [3:0]        step_q, step_d;
    logic              draw_en_q, draw_en_d;
    logic [3:0]        cmd_q, cmd_d;
    logic [31:0]       d1_q, d1_d, d2_q, d2_d;
    logic              fdone_q, fdone_d;
    logic              to_q, to_d;
    logic [7:0]        tcnt_q, tcnt_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [DATA_W-1:0] lat_q [NUM_CH];
    logic [DATA_W-1:0] lat_d [NUM_CH];

    logic [3:0]  cur_cmd;
    logic [63:0] cur_ops;
    logic        cur_skip;
    logic        advance;

`ifdef ZDRAW_SKIP_UNCHANGED_EN
    logic        first_q, first_d;
    logic [63:0] sh_q [3];
    logic [63:0] sh_d [3];
`endif

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            lat_d[c] = lat_q[c];
            if (!en || iPause) begin
                lat_d[c] = '0;
            end else if (iData_Update[c]) begin
                lat_d[c] = iPulse_Counter[c*DATA_W +: DATA_W];
            end
        end
    end

    // Command and operands for the current state / frame step
    always_comb begin
        cur_cmd  = 4'd0;
        cur_ops  = 64'd0;
        cur_skip = 1'b0;
        unique case (state_q)
            S_CLR: cur_ops = {32'(BG_COLOR), 32'd0};
            S_IMG: cur_cmd = 4'd1;
            S_LBL: cur_cmd = 4'd4;
            S_FRAME: begin
                if (step_q == 4'd0) begin
                    cur_cmd = 4'd2;
                end else if (step_q == 4'd1) begin
                    cur_cmd = 4'd3;
                end else if (step_q == 4'(LAST - 3)) begin
                    cur_cmd = 4'd7;
                end else if (step_q == 4'(LAST - 2)) begin
                    cur_cmd = 4'd8;
                    cur_ops = {32'(iPulseCounter_Accumulated), 32'd0};
                end else if (step_q == 4'(LAST - 1)) begin
                    cur_cmd = 4'd9;
                    cur_ops = {32'(iPulseCounter_Gain_Divider),
                               32'(iTime_Interval_Selection)};
                end else if (step_q == 4'(LAST)) begin
                    cur_cmd = 4'd10;
                    cur_ops = {32'(iMaxPulseCounter),
                               32'(iMinPulseCounter)};
                end
                for (int c = 0; c < NUM_CH; c++) begin
                    if (step_q == 4'(c + 2)) begin
                        cur_cmd = 4'd5;
                        cur_ops = {32'(lat_q[c]), 32'(c)};
                    end
                end
`ifdef ZDRAW_SKIP_UNCHANGED_EN
                if (!first_q) begin
                    cur_skip = (cur_cmd == 4'd8  && cur_ops == sh_q[0]) ||
                               (cur_cmd == 4'd9  && cur_ops == sh_q[1]) ||
                               (cur_cmd == 4'd10 && cur_ops == sh_q[2]);
                end
`endif
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        draw_en_d = draw_en_q;
        cmd_d     = cmd_q;
        d1_d      = d1_q;
        d2_d      = d2_q;
        fdone_d   = 1'b0;
        to_d      = to_q;
        tcnt_d    = tcnt_q;
        wd_d      = wd_q;
        advance   = 1'b0;
`ifdef ZDRAW_SKIP_UNCHANGED_EN
        first_d = first_q;
        for (int i = 0; i < 3; i++) sh_d[i] = sh_q[i];
`endif
        if (!en) begin
            state_d   = S_IDLE;
            step_d    = 4'd0;
            draw_en_d = 1'b0;
            to_d      = 1'b0;
            tcnt_d    = 8'd0;
        end else begin
            unique case (state_q)
                S_IDLE: state_d = S_CLR;
                S_WAIT: begin
                    if (!iPause) begin
                        state_d = S_FRAME;
                        step_d  = 4'd0;
                    end
                end
                default: begin
                    // Enable low here means the step has not been issued yet
                    if (!draw_en_q) begin
                        if (cur_skip) begin
                            advance = 1'b1;
                        end else begin
                            draw_en_d = 1'b1;
                            cmd_d     = cur_cmd;
                            d1_d      = cur_ops[63:32];
                            d2_d      = cur_ops[31:0];
                            wd_d      = '0;
`ifdef ZDRAW_SKIP_UNCHANGED_EN
                            if (cur_cmd == 4'd8)  sh_d[0] = cur_ops;
                            if (cur_cmd == 4'd9)  sh_d[1] = cur_ops;
                            if (cur_cmd == 4'd10) sh_d[2] = cur_ops;
`endif
                        end
                    end else if (iDraw_Done) begin
                        draw_en_d = 1'b0;
                        advance   = 1'b1;
                    end else if (wd_q == WD_LIM) begin
                        draw_en_d = 1'b0;
                        to_d      = 1'b1;
                        advance   = 1'b1;
                        if (tcnt_q != 8'hFF) tcnt_d = tcnt_q + 8'd1;
                    end else begin
                        wd_d = wd_q + WD_W'(1);
                    end

                    if (advance) begin
                        if (state_q == S_CLR) begin
                            state_d = S_IMG;
                        end else if (state_q == S_IMG) begin
                            state_d = S_LBL;
                        end else if (state_q == S_LBL) begin
                            state_d = S_WAIT;
`ifdef ZDRAW_SKIP_UNCHANGED_EN
                            first_d = 1'b1;
`endif
                        end else if (step_q == 4'(LAST)) begin
                            state_d = S_WAIT;
                            step_d  = 4'd0;
                            fdone_d = 1'b1;
`ifdef ZDRAW_SKIP_UNCHANGED_EN
                            first_d = 1'b0;
`endif
                        end else begin
                            step_d = step_q + 4'd1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            step_q    <= 4'd0;
            draw_en_q <= 1'b0;
            cmd_q     <= 4'd0;
            d1_q      <= 32'd0;
            d2_q      <= 32'd0;
            fdone_q   <= 1'b0;
            to_q      <= 1'b0;
            tcnt_q    <= 8'd0;
            wd_q      <= '0;
            lat_q     <= '{default: '0};
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            draw_en_q <= draw_en_d;
            cmd_q     <= cmd_d;
            d1_q      <= d1_d;
            d2_q      <= d2_d;
            fdone_q   <= fdone_d;
            to_q      <= to_d;
            tcnt_q    <= tcnt_d;
            wd_q      <= wd_d;
            lat_q     <= lat_d;
        end
    end

`ifdef ZDRAW_SKIP_UNCHANGED_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_q <= 1'b0;
            sh_q    <= '{default: '0};
        end else begin
            first_q <= first_d;
            sh_q    <= sh_d;
        end
    end
`endif

    assign oDraw_En     = draw_en_q;
    assign oBusy        = draw_en_q;
    assign oDraw_Cmd    = cmd_q;
    assign oDraw_Data1  = d1_q;
    assign oDraw_Data2  = d2_q;
    assign oFrame_Done  = fdone_q;
    assign oTimeout     = to_q;
    assign oTimeout_Cnt = tcnt_q;

endmodule

// File: tb/tb_zdraw_scheduler.sv
// tb_zdraw_scheduler: randomized bench for zdraw_scheduler with a done
// responder, a command logger and a frame-level reference model.
module tb_zdraw_scheduler;

    localparam int NCH = 2;
    localparam int DW  = 32;
    localparam int TO  = 16;
    localparam logic [15:0] BG = 16'hF81F;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        iPause = 1'b0;
    logic [1:0]  iData_Update = '0;
    logic [63:0] iPulse_Counter = '0;
    logic [31:0] iAcc = '0;
    logic [7:0]  iGain = '0;
    logic [7:0]  iIntv = '0;
    logic [15:0] iMax = '0;
    logic [15:0] iMin = '0;
    logic        iDraw_Done = 1'b0;
    logic        oDraw_En, oFrame_Done, oTimeout, oBusy;
    logic [3:0]  oDraw_Cmd;
    logic [31:0] oDraw_Data1, oDraw_Data2;
    logic [7:0]  oTimeout_Cnt;

    zdraw_scheduler #(
        .NUM_CH(NCH), .DATA_W(DW), .TIMEOUT_CYC(TO), .BG_COLOR(BG)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .iPause(iPause),
        .iData_Update(iData_Update), .iPulse_Counter(iPulse_Counter),
        .iPulseCounter_Accumulated(iAcc),
        .iPulseCounter_Gain_Divider(iGain),
        .iTime_Interval_Selection(iIntv),
        .iMaxPulseCounter(iMax), .iMinPulseCounter(iMin),
        .oDraw_En(oDraw_En), .oDraw_Cmd(oDraw_Cmd),
        .oDraw_Data1(oDraw_Data1), .oDraw_Data2(oDraw_Data2),
        .iDraw_Done(iDraw_Done), .oFrame_Done(oFrame_Done),
        .oTimeout(oTimeout), .oTimeout_Cnt(oTimeout_Cnt), .oBusy(oBusy)
    );

    always #5 clk = ~clk;

    typedef logic [67:0] ent_t;
    ent_t log_q[$];
    ent_t exp_q[$];

    int pass_cnt = 0;
    int tot_cnt = 0;

    // responder / monitor state
    int   lat = 3;
    int   rcnt = 0;
    bit   hang_en = 0;
    bit   hang_all = 0;
    logic [3:0] hang_cmd = 4'd0;
    bit   en_prev = 0;
    ent_t prev = '0;
    int   run = 0;
    int   to_run = 0;
    int   to_cnt_m = 0;
    int   fd_cnt = 0;
    int   hold_err = 0;
    int   busy_err = 0;

    // reference model state
    logic [31:0] lat_m [NCH];
    bit          first_m = 0;
    logic [63:0] sh_m [3];

    always @(negedge clk) begin
        if (rst_n) begin
            if (oDraw_En && !en_prev) begin
                log_q.push_back({oDraw_Cmd, oDraw_Data1, oDraw_Data2});
                run = 0;
            end
            if (oDraw_En && en_prev &&
                {oDraw_Cmd, oDraw_Data1, oDraw_Data2} != prev) hold_err++;
            if (oDraw_En) run++;
            if (!oDraw_En && en_prev && !iDraw_Done) begin
                to_cnt_m++;
                to_run = run;
            end
            if (oBusy !== oDraw_En) busy_err++;
            if (oFrame_Done) fd_cnt++;
            en_prev = oDraw_En;
            prev = {oDraw_Cmd, oDraw_Data1, oDraw_Data2};
        end
        if (iDraw_Done) begin
            iDraw_Done = 1'b0;
            rcnt = 0;
        end else if (oDraw_En && !hang_all &&
                     !(hang_en && oDraw_Cmd == hang_cmd)) begin
            rcnt++;
            if (rcnt >= lat) iDraw_Done = 1'b1;
        end else begin
            rcnt = 0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    function automatic void push_init();
        exp_q.push_back({4'd0, 16'd0, BG, 32'd0});
        exp_q.push_back({4'd1, 64'd0});
        exp_q.push_back({4'd4, 64'd0});
        first_m = 1;
    endfunction

    function automatic void push_frame();
        logic [63:0] ops [3];
        ops[0] = {iAcc, 32'd0};
        ops[1] = {24'd0, iGain, 24'd0, iIntv};
        ops[2] = {16'd0, iMax, 16'd0, iMin};
        exp_q.push_back({4'd2, 64'd0});
        exp_q.push_back({4'd3, 64'd0});
        for (int c = 0; c < NCH; c++) exp_q.push_back({4'd5, lat_m[c], 32'(c)});
        exp_q.push_back({4'd7, 64'd0});
        for (int k = 0; k < 3; k++) begin
`ifdef ZDRAW_SKIP_UNCHANGED_EN
            if (first_m || ops[k] != sh_m[k]) begin
`else
            begin
`endif
                exp_q.push_back({4'(k + 8), ops[k]});
                sh_m[k] = ops[k];
            end
        end
        first_m = 0;
    endfunction

    task automatic set_static();
        iAcc  = $urandom;
        iGain = 8'($urandom_range(0, 255));
        iIntv = 8'($urandom_range(0, 255));
        iMax  = 16'($urandom_range(0, 65535));
        iMin  = 16'($urandom_range(0, 65535));
    endtask

    task automatic wait_frame_done(input string nm);
        bit seen = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (oFrame_Done) begin
                seen = 1;
                break;
            end
        end
        iPause = 1'b1;
        tot_cnt++;
        if (!seen) $display("FAIL %s_frame_done: no pulse within 3000 cycles", nm);
        else pass_cnt++;
    endtask

    // Starts one frame from WAIT_RUN (paused), loading latches on the start edge
    task automatic run_frame(input logic [1:0] upd, input logic [63:0] cnt,
                             input string nm);
        @(negedge clk);
        iPause = 1'b0;
        iData_Update = upd;
        iPulse_Counter = cnt;
        for (int c = 0; c < NCH; c++) lat_m[c] = upd[c] ? cnt[c*32 +: 32] : 32'd0;
        push_frame();
        @(negedge clk);
        iData_Update = '0;
        wait_frame_done(nm);
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] o [8];
        string nm [8] = '{"en", "cmd", "data1", "data2", "frame_done",
                          "timeout", "timeout_cnt", "busy"};
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        o[0] = 32'(oDraw_En);    o[1] = 32'(oDraw_Cmd);
        o[2] = oDraw_Data1;      o[3] = oDraw_Data2;
        o[4] = 32'(oFrame_Done); o[5] = 32'(oTimeout);
        o[6] = 32'(oTimeout_Cnt); o[7] = 32'(oBusy);
        for (int i = 0; i < 8; i++) begin
            tot_cnt++;
            if (o[i] !== 32'd0) $display("FAIL reset_%s: got %h expected 0", nm[i], o[i]);
            else pass_cnt++;
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        tot_cnt++;
        if (oDraw_En !== 1'b0) $display("FAIL idle_en: got %b expected 0 with en low", oDraw_En);
        else pass_cnt++;
    endtask

    task automatic test_power_on();
        log_q.delete(); exp_q.delete();
        fd_cnt = 0; hold_err = 0; busy_err = 0;
        set_static();
        for (int c = 0; c < NCH; c++) lat_m[c] = 32'd0;
        push_init();
        push_frame();
        en = 1'b1;
        iPause = 1'b0;
        @(negedge clk);
        tot_cnt++;
        if (oDraw_En !== 1'b0) $display("FAIL pwr_latency_early: en got %b expected 0", oDraw_En);
        else pass_cnt++;
        @(negedge clk);
        tot_cnt++;
        if ({oDraw_En, oDraw_Cmd, oDraw_Data1} !== {1'b1, 4'd0, 16'd0, BG})
            $display("FAIL pwr_first_cmd: got en=%b cmd=%0d d1=%h expected en=1 cmd=0 d1=%h",
                     oDraw_En, oDraw_Cmd, oDraw_Data1, BG);
        else pass_cnt++;
        wait_frame_done("pwr");
        repeat (5) @(negedge clk);
        tot_cnt++;
        if (log_q.size() != exp_q.size())
            $display("FAIL pwr_len: got %0d cmds expected %0d", log_q.size(), exp_q.size());
        else pass_cnt++;
        for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
            tot_cnt++;
            if (log_q[i] !== exp_q[i])
                $display("FAIL pwr_cmd[%0d]: got %h expected %h", i, log_q[i], exp_q[i]);
            else pass_cnt++;
        end
        log_q.delete(); exp_q.delete();
        tot_cnt++;
        if (fd_cnt != 1) $display("FAIL pwr_frame_pulses: got %0d expected 1", fd_cnt);
        else pass_cnt++;
        tot_cnt++;
        if (hold_err != 0 || busy_err != 0)
            $display("FAIL pwr_handshake: got hold_err=%0d busy_err=%0d expected 0/0",
                     hold_err, busy_err);
        else pass_cnt++;
    endtask

    task automatic test_channel_latch();
        run_frame(2'b10, {32'h0000_1234, 32'hDEAD_BEEF}, "latch");
        run_frame(2'b00, {$urandom, $urandom}, "latch_clr");
        tot_cnt++;
        if (log_q.size() != exp_q.size())
            $display("FAIL latch_len: got %0d cmds expected %0d", log_q.size(), exp_q.size());
        else pass_cnt++;
        for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
            tot_cnt++;
            if (log_q[i] !== exp_q[i])
                $display("FAIL latch_cmd[%0d]: got %h expected %h", i, log_q[i], exp_q[i]);
            else pass_cnt++;
        end
        log_q.delete(); exp_q.delete();
    endtask

    task automatic test_random_frames();
        hold_err = 0; busy_err = 0;
        for (int f = 0; f < 5; f++) begin
            lat = $urandom_range(1, 5);
            set_static();
            run_frame(2'($urandom_range(0, 3)), {$urandom, $urandom}, "rand");
        end
        lat = 3;
        tot_cnt++;
        if (log_q.size() != exp_q.size())
            $display("FAIL rand_len: got %0d cmds expected %0d", log_q.size(), exp_q.size());
        else pass_cnt++;
        for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
            tot_cnt++;
            if (log_q[i] !== exp_q[i])
                $display("FAIL rand_cmd[%0d]: got %h expected %h", i, log_q[i], exp_q[i]);
            else pass_cnt++;
        end
        log_q.delete(); exp_q.delete();
        tot_cnt++;
        if (hold_err != 0 || busy_err != 0)
            $display("FAIL rand_handshake: got hold_err=%0d busy_err=%0d expected 0/0",
                     hold_err, busy_err);
        else pass_cnt++;
    endtask

    task automatic test_pause_mid_frame();
        bit   hit = 0;
        int   n_done;
        set_static();
        @(negedge clk);
        iPause = 1'b0;
        iData_Update = 2'b11;
        iPulse_Counter = {$urandom, $urandom};
        @(negedge clk);
        iData_Update = '0;
        for (int i = 0; i < 200; i++) begin
            if (log_q.size() >= 2) begin
                hit = 1;
                break;
            end
            @(negedge clk);
        end
        iPause = 1'b1;
        tot_cnt++;
        if (!hit) $display("FAIL pause_reach_cmd3: got %0d cmds expected >=2", log_q.size());
        else pass_cnt++;
        for (int c = 0; c < NCH; c++) lat_m[c] = 32'd0;
        push_frame();
        wait_frame_done("pause");
        n_done = log_q.size();
        repeat (60) @(negedge clk);
        tot_cnt++;
        if (log_q.size() != n_done || oDraw_En !== 1'b0)
            $display("FAIL pause_hold: got %0d new cmds en=%b expected 0 new en=0",
                     log_q.size() - n_done, oDraw_En);
        else pass_cnt++;
        tot_cnt++;
        if (log_q.size() != exp_q.size())
            $display("FAIL pause_len: got %0d cmds expected %0d", log_q.size(), exp_q.size());
        else pass_cnt++;
        for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
            tot_cnt++;
            if (log_q[i] !== exp_q[i])
                $display("FAIL pause_cmd[%0d]: got %h expected %h", i, log_q[i], exp_q[i]);
            else pass_cnt++;
        end
        log_q.delete(); exp_q.delete();
    endtask

    task automatic test_timeout();
        int idx = -1;
        hang_cmd = 4'd3;
        hang_en = 1;
        to_cnt_m = 0;
        to_run = 0;
        run_frame(2'b00, 64'd0, "to");
        hang_en = 0;
        tot_cnt++;
        if (to_run != TO - 1) $display("FAIL to_en_cycles: got %0d expected %0d", to_run, TO - 1);
        else pass_cnt++;
        tot_cnt++;
        if (oTimeout !== 1'b1 || oTimeout_Cnt !== 8'd1)
            $display("FAIL to_flags: got to=%b cnt=%0d expected to=1 cnt=1", oTimeout, oTimeout_Cnt);
        else pass_cnt++;
        for (int i = 0; i < log_q.size(); i++) begin
            if (log_q[i][67:64] == 4'd3) begin
                idx = i;
                break;
            end
        end
        tot_cnt++;
        if (idx < 0 || idx + 1 >= log_q.size() || log_q[idx+1][67:64] != 4'd5)
            $display("FAIL to_next_cmd: got idx=%0d size=%0d expected cmd 5 after cmd 3",
                     idx, log_q.size());
        else pass_cnt++;
        tot_cnt++;
        if (log_q.size() != exp_q.size())
            $display("FAIL to_len: got %0d cmds expected %0d", log_q.size(), exp_q.size());
        else pass_cnt++;
        for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
            tot_cnt++;
            if (log_q[i] !== exp_q[i])
                $display("FAIL to_cmd[%0d]: got %h expected %h", i, log_q[i], exp_q[i]);
            else pass_cnt++;
        end
        log_q.delete(); exp_q.delete();
    endtask

    task automatic test_timeout_saturate();
        int exp_cnt;
        hang_all = 1;
        for (int f = 0; f < 40; f++) run_frame(2'b00, 64'd0, "sat");
        hang_all = 0;
        exp_cnt = (to_cnt_m > 255) ? 255 : to_cnt_m;
        tot_cnt++;
        if (oTimeout_Cnt !== 8'(exp_cnt) || exp_cnt != 255)
            $display("FAIL sat_cnt: got %0d expected %0d (expiries seen %0d)",
                     oTimeout_Cnt, exp_cnt, to_cnt_m);
        else pass_cnt++;
        tot_cnt++;
        if (oTimeout !== 1'b1) $display("FAIL sat_sticky: got %b expected 1", oTimeout);
        else pass_cnt++;
        tot_cnt++;
        if (log_q.size() != exp_q.size())
            $display("FAIL sat_len: got %0d cmds expected %0d", log_q.size(), exp_q.size());
        else pass_cnt++;
        for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
            tot_cnt++;
            if (log_q[i] !== exp_q[i])
                $display("FAIL sat_cmd[%0d]: got %h expected %h", i, log_q[i], exp_q[i]);
            else pass_cnt++;
        end
        log_q.delete(); exp_q.delete();
    endtask

    task automatic test_en_low();
        bit hit = 0;
        @(negedge clk);
        iPause = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (oDraw_En && oDraw_Cmd == 4'd5) begin
                hit = 1;
                break;
            end
        end
        en = 1'b0;
        tot_cnt++;
        if (!hit) $display("FAIL enlow_reach_cmd5: cmd 5 not outstanding within 500 cycles");
        else pass_cnt++;
        @(negedge clk);
        tot_cnt++;
        if ({oDraw_En, oBusy, oTimeout, oTimeout_Cnt} !== 11'd0)
            $display("FAIL enlow_outputs: got en=%b busy=%b to=%b cnt=%0d expected all 0",
                     oDraw_En, oBusy, oTimeout, oTimeout_Cnt);
        else pass_cnt++;
        iPause = 1'b1;
        repeat (3) @(negedge clk);
        log_q.delete(); exp_q.delete();
        to_cnt_m = 0;
        push_init();
        en = 1'b1;
        repeat (60) @(negedge clk);
        tot_cnt++;
        if (oTimeout !== 1'b0 || oTimeout_Cnt !== 8'd0)
            $display("FAIL reen_flags: got to=%b cnt=%0d expected 0/0", oTimeout, oTimeout_Cnt);
        else pass_cnt++;
        tot_cnt++;
        if (log_q.size() != exp_q.size())
            $display("FAIL reen_len: got %0d cmds expected %0d", log_q.size(), exp_q.size());
        else pass_cnt++;
        for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
            tot_cnt++;
            if (log_q[i] !== exp_q[i])
                $display("FAIL reen_cmd[%0d]: got %h expected %h", i, log_q[i], exp_q[i]);
            else pass_cnt++;
        end
        log_q.delete(); exp_q.delete();
    endtask

    task automatic test_unchanged();
        int b_len;
`ifdef ZDRAW_SKIP_UNCHANGED_EN
        b_len = 5;
`else
        b_len = 8;
`endif
        set_static();
        iMax = 16'd100;
        run_frame(2'b00, 64'd0, "unch_a");
        log_q.delete(); exp_q.delete();
        run_frame(2'b00, 64'd0, "unch_b");
        tot_cnt++;
        if (log_q.size() != b_len)
            $display("FAIL unch_static_len: got %0d cmds expected %0d", log_q.size(), b_len);
        else pass_cnt++;
        iMax = 16'd101;
        run_frame(2'b00, 64'd0, "unch_c");
        tot_cnt++;
        if (log_q.size() == 0 || log_q[log_q.size()-1] !== {4'd10, 32'd101, 16'd0, iMin})
            $display("FAIL unch_max_change: got %h expected %h",
                     (log_q.size() > 0) ? log_q[log_q.size()-1] : ent_t'(0),
                     {4'd10, 32'd101, 16'd0, iMin});
        else pass_cnt++;
        tot_cnt++;
        if (log_q.size() != exp_q.size())
            $display("FAIL unch_len: got %0d cmds expected %0d", log_q.size(), exp_q.size());
        else pass_cnt++;
        for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
            tot_cnt++;
            if (log_q[i] !== exp_q[i])
                $display("FAIL unch_cmd[%0d]: got %h expected %h", i, log_q[i], exp_q[i]);
            else pass_cnt++;
        end
        log_q.delete(); exp_q.delete();
    endtask

    initial begin
        for (int k = 0; k < 3; k++) sh_m[k] = 64'd0;
        test_reset();
        test_power_on();
        test_channel_latch();
        test_random_frames();
        test_pause_mid_frame();
        test_timeout();
        test_timeout_saturate();
        test_en_low();
        test_unchanged();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
